riscvlong_vec_mem_unit: RTL and testbench
=========================================

Name: riscvlong_vec_mem_unit

Overview:
Parametrised vector memory access unit for the 7-stage core. It replaces the fixed four hand-instanced vector data-memory ports with NUM_LANES lanes, each with its own val/rdy request port and val-only response port. One command from the vector pipeline produces a strided, masked gather or scatter across all lanes. Load data is collected per lane and returned as one packed response. The unit sits between the core control/datapath and the per-lane data-memory ports.

Parameters:
NUM_LANES, 4, number of vector lanes and memory ports (1..16)
ADDR_SZ, 32, memory address width
DATA_SZ, 32, per-lane data width; fixed at 32 to match the vc memory message format

Ports:
clk  in  1  core clock
reset  in  1  reset; synchronous, active-high
cmd_val  in  1  command valid
cmd_rdy  out  1  command ready
cmd_rw  in  1  0 = load, 1 = store; same coding as the vc request type field
cmd_len  in  2  vc length field (0 = word, 1 = byte, 2 = half)
cmd_base  in  32  address for lane 0
cmd_stride  in  32  byte stride between lanes, two's complement
cmd_mask  in  NUM_LANES  lane enable; bit i controls lane i
cmd_wdata  in  NUM_LANES*32  store data; lane i is bits [32i+31:32i]
resp_val  out  1  result valid
resp_rdy  in  1  result ready
resp_data  out  NUM_LANES*32  load data per lane; masked lanes and stores return 0
memreq_msg  out  NUM_LANES*67  per-lane request; lane i field layout {type, addr[31:0], len[1:0], data[31:0]}, type is the MSB
memreq_val  out  NUM_LANES  per-lane request valid
memreq_rdy  in  NUM_LANES  per-lane request ready
memresp_msg  in  NUM_LANES*35  per-lane response; layout {type, len[1:0], data[31:0]}
memresp_val  in  NUM_LANES  per-lane response valid; there is no response ready

Behaviour:
- FSM states: IDLE, BUSY, DONE. Reset forces IDLE, clears all per-lane issued, got and data registers, and the latched command.
- Outputs at reset: cmd_rdy=1, resp_val=0, memreq_val=0, resp_data=0.
- IDLE:
  - cmd_rdy=1.
  - On cmd_val, latch rw, len, base, stride, mask and wdata; clear issued, got and data.
  - Next state is BUSY, or DONE if cmd_mask==0.
- BUSY:
  - memreq_val[i] = mask[i] & ~issued[i].
  - addr_i = base + i*stride, modulo 2^32 (wrap-around is legal).
  - Request data field = wdata lane i for stores, 0 for loads.
  - issued[i] is set on memreq_val[i] & memreq_rdy[i].
  - Lanes issue independently and in any order. A stalled lane never blocks the other lanes.
  - A request is held stable while val=1 and rdy=0.
- Response capture:
  - On memresp_val[i] & issued[i] & ~got[i], set got[i]; for loads only, also capture data into lane i.
  - A response on a lane with no outstanding request, or a duplicate response, is ignored. It does not change state.
  - A request accepted in cycle t must not see its response before t+1; the unit does not need to forward a same-cycle response.
- BUSY -> DONE in the cycle after the last unmasked lane's response is captured. That is: when (got | captured-this-cycle) covers the mask, the next state is DONE.
- DONE:
  - resp_val=1 and resp_data holds its value.
  - On resp_rdy, go to IDLE.
  - cmd_rdy=0 in both BUSY and DONE, so there is only one command in flight. No command is accepted in the same cycle DONE retires.
- Latency: command accepted at cycle 0 → requests at cycle 1 → responses at cycle 2 (1-cycle memory, all rdy=1) → resp_val at cycle 3. Back-to-back commands complete every 4 cycles.
- Load data is returned raw. Sign or zero extension of byte and half accesses is done by the consumer.
- Reset asserted mid-operation: the command is abandoned and the FSM goes to IDLE. Responses that arrive after reset fall under the "no outstanding request" rule and are ignored.

Decomposition:
- Shared package (riscvlong-VecMemUnit-defs): state encodings, message field offsets and widths (REQ 67/RESP 35 derived from the VC_MEM macros), and the rw coding.
- Sub-module riscvlong_vec_mem_lane, one instance per lane via generate. It holds the issued/got/data registers, the address calculation, request packing (vc_MemReqMsgToBits) and response unpacking.
- The top level holds the FSM, command latch and completion reduction.

Test Plan:
- Unit-stride load, mask=4'b1111, base=0x1000, stride=4, 1-cycle memory with all rdy=1 → addrs 0x1000/04/08/0C issued at cycle 1; resp_val at cycle 3; resp_data equals the four memory words.
- Strided store, stride=0xFFFFFFF8 (−8), base=0x2000, mask=4'b1111, wdata lanes 0xA..0xD → addrs 0x2000, 0x1FF8, 0x1FF0, 0x1FE8 with type=1 and matching data; resp_data=0.
- Partial mask 4'b0101 on a load → only lanes 0 and 2 issue; resp_data lanes 1 and 3 = 0. Mask=0 → no requests; resp_val at cycle 1 after accept.
- Backpressure: memreq_rdy[2] held 0 for 5 cycles, other lanes ready → lanes 0, 1, 3 complete; lane 2's msg stays stable; resp_val one cycle after lane 2's response.
- Out-of-order and spurious responses: responses arrive in lane order 3, 0, 2, 1, and lane 1 sends an extra memresp_val after completion → correct per-lane data; the extra response has no effect. resp_rdy=0 for 3 cycles → resp_val and resp_data held, cmd_rdy=0.
- Reset pulsed while two lanes are outstanding → next cycle IDLE, cmd_rdy=1; late responses are ignored; the following command returns correct data.

Source files
------------

// File: rtl/riscvlong_vec_mem_unit_pkg.sv
// Shared definitions for the vector memory unit: FSM state encodings,
// vc memory message layouts and the load/store coding of the type field.
package riscvlong_vec_mem_unit_pkg;

  // FSM state encodings
  localparam int unsigned STATE_SZ = 2;
  localparam logic [STATE_SZ-1:0] STATE_IDLE = 2'd0;
  localparam logic [STATE_SZ-1:0] STATE_BUSY = 2'd1;
  localparam logic [STATE_SZ-1:0] STATE_DONE = 2'd2;

  // vc memory message field widths
  localparam int unsigned MEM_TYPE_SZ = 1;
  localparam int unsigned MEM_ADDR_SZ = 32;
  localparam int unsigned MEM_LEN_SZ  = 2;
  localparam int unsigned MEM_DATA_SZ = 32;

  // Request message is {type, addr, len, data}, type in the MSB
  localparam int unsigned MEMREQ_MSG_SZ   = MEM_TYPE_SZ + MEM_ADDR_SZ + MEM_LEN_SZ + MEM_DATA_SZ;
  localparam int unsigned MEMREQ_DATA_LSB = 0;
  localparam int unsigned MEMREQ_LEN_LSB  = MEMREQ_DATA_LSB + MEM_DATA_SZ;
  localparam int unsigned MEMREQ_ADDR_LSB = MEMREQ_LEN_LSB + MEM_LEN_SZ;
  localparam int unsigned MEMREQ_TYPE_BIT = MEMREQ_ADDR_LSB + MEM_ADDR_SZ;

  // Response message is {type, len, data}, type in the MSB
  localparam int unsigned MEMRESP_MSG_SZ   = MEM_TYPE_SZ + MEM_LEN_SZ + MEM_DATA_SZ;
  localparam int unsigned MEMRESP_DATA_LSB = 0;
  localparam int unsigned MEMRESP_LEN_LSB  = MEMRESP_DATA_LSB + MEM_DATA_SZ;
  localparam int unsigned MEMRESP_TYPE_BIT = MEMRESP_LEN_LSB + MEM_LEN_SZ;

  // Type field coding, shared by the command rw bit
  localparam logic RW_LOAD  = 1'b0;
  localparam logic RW_STORE = 1'b1;

  typedef struct packed {
    logic                   rw;
    logic [MEM_ADDR_SZ-1:0] addr;
    logic [MEM_LEN_SZ-1:0]  len;
    logic [MEM_DATA_SZ-1:0] data;
  } mem_req_t;

  typedef struct packed {
    logic                   rw;
    logic [MEM_LEN_SZ-1:0]  len;
    logic [MEM_DATA_SZ-1:0] data;
  } mem_resp_t;

  // Pack request fields into the flat vc request message
  function automatic logic [MEMREQ_MSG_SZ-1:0] mem_req_msg_to_bits(
    input logic                   rw,
    input logic [MEM_ADDR_SZ-1:0] addr,
    input logic [MEM_LEN_SZ-1:0]  len,
    input logic [MEM_DATA_SZ-1:0] data
  );
    mem_req_t req;
    req.rw   = rw;
    req.addr = addr;
    req.len  = len;
    req.data = data;
    return req;
  endfunction

endpackage

// File: rtl/riscvlong_vec_mem_unit_lane.sv
// One lane of the vector memory unit: computes the lane address, issues a
// single request when enabled, and captures the first matching response.
module riscvlong_vec_mem_lane
  import riscvlong_vec_mem_unit_pkg::*;
#(
  parameter int unsigned LANE_IDX = 0,
  parameter int unsigned ADDR_SZ  = 32,
  parameter int unsigned DATA_SZ  = 32
)(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      busy,
  input  logic                      rw,
  input  logic [MEM_LEN_SZ-1:0]     len,
  input  logic [ADDR_SZ-1:0]        base,
  input  logic [ADDR_SZ-1:0]        stride,
  input  logic                      mask,
  input  logic [DATA_SZ-1:0]        wdata,
  output logic [MEMREQ_MSG_SZ-1:0]  memreq_msg,
  output logic                      memreq_val,
  input  logic                      memreq_rdy,
  input  logic [MEMRESP_MSG_SZ-1:0] memresp_msg,
  input  logic                      memresp_val,
  output logic                      got,
  output logic                      capture,
  output logic [DATA_SZ-1:0]        data
);

  logic               issued_r;
  logic               got_r;
  logic [DATA_SZ-1:0] data_r;
  logic [ADDR_SZ-1:0] addr;
  logic [DATA_SZ-1:0] req_data;
  mem_resp_t          resp;
  logic               unused_resp_bits;

  // Lane address wraps modulo 2^ADDR_SZ, so negative strides just work
  assign addr     = base + stride * ADDR_SZ'(LANE_IDX);
  assign req_data = (rw == RW_STORE) ? wdata : '0;

  // Request fields come only from latched command state, so the message is
  // stable for as long as the request is stalled
  assign memreq_msg = mem_req_msg_to_bits(rw, addr, len, req_data);
  assign memreq_val = busy & mask & ~issued_r;

  // Only the first response to an outstanding request is taken
  assign resp    = memresp_msg;
  assign capture = memresp_val & issued_r & ~got_r;

  // Type and length of a response carry no information we need here
  assign unused_resp_bits = ^{resp.rw, resp.len};

  assign got  = got_r;
  assign data = data_r;

  // Per-lane progress and load data, wiped whenever a new command starts
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      issued_r <= 1'b0;
      got_r    <= 1'b0;
      data_r   <= '0;
    end else begin
      if (memreq_val && memreq_rdy) begin
        issued_r <= 1'b1;
      end
      if (capture) begin
        got_r <= 1'b1;
        if (rw == RW_LOAD) begin
          data_r <= resp.data;
        end
      end
    end
  end

endmodule

// File: rtl/riscvlong_vec_mem_unit.sv
// Vector memory access unit: takes one strided, masked gather/scatter
// command at a time, fans it out over NUM_LANES memory ports and returns
// the collected load data as one packed response.
module riscvlong_vec_mem_unit
  import riscvlong_vec_mem_unit_pkg::*;
#(
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned ADDR_SZ   = 32,
  parameter int unsigned DATA_SZ   = 32
)(
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                cmd_val,
  output logic                                cmd_rdy,
  input  logic                                cmd_rw,
  input  logic [MEM_LEN_SZ-1:0]               cmd_len,
  input  logic [ADDR_SZ-1:0]                  cmd_base,
  input  logic [ADDR_SZ-1:0]                  cmd_stride,
  input  logic [NUM_LANES-1:0]                cmd_mask,
  input  logic [NUM_LANES*DATA_SZ-1:0]        cmd_wdata,
  output logic                                resp_val,
  input  logic                                resp_rdy,
  output logic [NUM_LANES*DATA_SZ-1:0]        resp_data,
  output logic [NUM_LANES*MEMREQ_MSG_SZ-1:0]  memreq_msg,
  output logic [NUM_LANES-1:0]                memreq_val,
  input  logic [NUM_LANES-1:0]                memreq_rdy,
  input  logic [NUM_LANES*MEMRESP_MSG_SZ-1:0] memresp_msg,
  input  logic [NUM_LANES-1:0]                memresp_val
);

  logic [STATE_SZ-1:0]          state_r;
  logic [STATE_SZ-1:0]          state_next;

  logic                         rw_r;
  logic [MEM_LEN_SZ-1:0]        len_r;
  logic [ADDR_SZ-1:0]           base_r;
  logic [ADDR_SZ-1:0]           stride_r;
  logic [NUM_LANES-1:0]         mask_r;
  logic [NUM_LANES*DATA_SZ-1:0] wdata_r;

  logic                         cmd_go;
  logic                         busy;
  logic                         lanes_done;
  logic [NUM_LANES-1:0]         got;
  logic [NUM_LANES-1:0]         capture;

  assign cmd_rdy  = (state_r == STATE_IDLE);
  assign resp_val = (state_r == STATE_DONE);
  assign busy     = (state_r == STATE_BUSY);
  assign cmd_go   = cmd_val & cmd_rdy;

  // Done once every enabled lane has its response, counting this cycle's
  assign lanes_done = ((got | capture) & mask_r) == mask_r;

  // Next-state logic: one command in flight, no accept while retiring
  always_comb begin
    state_next = state_r;
    case (state_r)
      STATE_IDLE: if (cmd_val) state_next = (cmd_mask == '0) ? STATE_DONE : STATE_BUSY;
      STATE_BUSY: if (lanes_done) state_next = STATE_DONE;
      STATE_DONE: if (resp_rdy) state_next = STATE_IDLE;
      default:    state_next = STATE_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= STATE_IDLE;
    end else begin
      state_r <= state_next;
    end
  end

  // Command latch, held for the whole life of the command
  always_ff @(posedge clk) begin
    if (reset) begin
      rw_r     <= RW_LOAD;
      len_r    <= '0;
      base_r   <= '0;
      stride_r <= '0;
      mask_r   <= '0;
      wdata_r  <= '0;
    end else if (cmd_go) begin
      rw_r     <= cmd_rw;
      len_r    <= cmd_len;
      base_r   <= cmd_base;
      stride_r <= cmd_stride;
      mask_r   <= cmd_mask;
      wdata_r  <= cmd_wdata;
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    riscvlong_vec_mem_lane #(
      .LANE_IDX (i),
      .ADDR_SZ  (ADDR_SZ),
      .DATA_SZ  (DATA_SZ)
    ) u_lane (
      .clk         (clk),
      .reset       (reset),
      .clear       (cmd_go),
      .busy        (busy),
      .rw          (rw_r),
      .len         (len_r),
      .base        (base_r),
      .stride      (stride_r),
      .mask        (mask_r[i]),
      .wdata       (wdata_r[i*DATA_SZ +: DATA_SZ]),
      .memreq_msg  (memreq_msg[i*MEMREQ_MSG_SZ +: MEMREQ_MSG_SZ]),
      .memreq_val  (memreq_val[i]),
      .memreq_rdy  (memreq_rdy[i]),
      .memresp_msg (memresp_msg[i*MEMRESP_MSG_SZ +: MEMRESP_MSG_SZ]),
      .memresp_val (memresp_val[i]),
      .got         (got[i]),
      .capture     (capture[i]),
      .data        (resp_data[i*DATA_SZ +: DATA_SZ])
    );
  end

endmodule

// File: tb/tb_riscvlong_vec_mem_unit.sv
// Self-checking bench for riscvlong_vec_mem_unit with four lanes. Expected
// requests and responses are queued by the stimulus and checked by
// independent monitors; a simple 1-cycle memory answers requests.
module tb_riscvlong_vec_mem_unit;

  localparam int NL = 4;
  localparam int RQ = 67;
  localparam int RS = 35;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            cmd_val;
  logic            cmd_rdy;
  logic            cmd_rw;
  logic [1:0]      cmd_len;
  logic [31:0]     cmd_base;
  logic [31:0]     cmd_stride;
  logic [NL-1:0]   cmd_mask;
  logic [NL*32-1:0] cmd_wdata;
  logic            resp_val;
  logic            resp_rdy;
  logic [NL*32-1:0] resp_data;
  logic [NL*RQ-1:0] memreq_msg;
  logic [NL-1:0]   memreq_val;
  logic [NL-1:0]   memreq_rdy;
  logic [NL*RS-1:0] memresp_msg;
  logic [NL-1:0]   memresp_val;

  logic [NL-1:0]    auto_val;
  logic [NL*RS-1:0] auto_msg;
  logic [NL-1:0]    man_val;
  logic [NL*RS-1:0] man_msg;
  logic             auto_mem;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [RQ-1:0]    exp_req_q [NL][$];
  logic [NL*32-1:0] exp_resp_q [$];

  riscvlong_vec_mem_unit #(.NUM_LANES(NL), .ADDR_SZ(32), .DATA_SZ(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_val     (cmd_val),
    .cmd_rdy     (cmd_rdy),
    .cmd_rw      (cmd_rw),
    .cmd_len     (cmd_len),
    .cmd_base    (cmd_base),
    .cmd_stride  (cmd_stride),
    .cmd_mask    (cmd_mask),
    .cmd_wdata   (cmd_wdata),
    .resp_val    (resp_val),
    .resp_rdy    (resp_rdy),
    .resp_data   (resp_data),
    .memreq_msg  (memreq_msg),
    .memreq_val  (memreq_val),
    .memreq_rdy  (memreq_rdy),
    .memresp_msg (memresp_msg),
    .memresp_val (memresp_val)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory responses come from the automatic responder or from directed drives
  assign memresp_val = auto_val | man_val;
  always_comb begin
    memresp_msg = man_msg;
    for (int i = 0; i < NL; i++)
      if (auto_val[i]) memresp_msg[i*RS +: RS] = auto_msg[i*RS +: RS];
  end

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return addr ^ 32'h5A5A0000;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic nextCycle;
    @(posedge clk);
    #1;
  endtask

  task automatic expectReq(input int lane, input logic rw, input logic [31:0] addr,
                           input logic [1:0] len, input logic [31:0] data);
    exp_req_q[lane].push_back({rw, addr, len, data});
  endtask

  task automatic manDrive(input logic [NL-1:0] v, input logic [NL*32-1:0] d);
    man_val = v;
    for (int i = 0; i < NL; i++) man_msg[i*RS +: RS] = {1'b0, 2'b00, d[i*32 +: 32]};
  endtask

  // Presents a command and returns the cycle stamp just after its acceptance
  task automatic applyStimulus(input logic rw, input logic [1:0] len, input logic [31:0] base,
                               input logic [31:0] stride, input logic [NL-1:0] mask,
                               input logic [NL*32-1:0] wdata, output int acc);
    int n;
    n = 0;
    cmd_val = 1'b1; cmd_rw = rw; cmd_len = len; cmd_base = base;
    cmd_stride = stride; cmd_mask = mask; cmd_wdata = wdata;
    @(negedge clk);
    while (!cmd_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_rdy) begin
      vectors++; miscompares++;
      $display("[TB] FAIL cmd_accept_timeout: got cmd_rdy=0 expected 1 within 50 cycles");
    end
    @(posedge clk);
    #1;
    cmd_val = 1'b0;
    acc = cyc;
  endtask

  // Waits (bounded) for resp_val and checks the cycle it appeared
  task automatic waitResp(input string name, input int acc, input int exp_lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!resp_val && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!resp_val) begin
      vectors++; miscompares++;
      $display("[TB] FAIL %s: got no resp_val expected latency %0d", name, exp_lat);
    end else begin
      checkOutput(name, 128'(cyc - acc + 1), 128'(exp_lat));
    end
    @(posedge clk);
    #1;
  endtask

  // 1-cycle memory: answers each accepted request in the following cycle
  initial begin
    logic [NL-1:0] fire;
    logic [RQ-1:0] req [NL];
    auto_val = '0;
    auto_msg = '0;
    forever begin
      @(negedge clk);
      fire = memreq_val & memreq_rdy & {NL{auto_mem & ~reset}};
      for (int i = 0; i < NL; i++) req[i] = memreq_msg[i*RQ +: RQ];
      @(posedge clk);
      #1;
      auto_val = fire;
      for (int i = 0; i < NL; i++)
        auto_msg[i*RS +: RS] = req[i][66] ? {1'b1, 2'b00, 32'h0}
                                           : {1'b0, req[i][33:32], mem_word(req[i][65:34])};
    end
  end

  // Request monitor: every valid request must match the head of its lane queue
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        for (int i = 0; i < NL; i++) begin
          if (memreq_val[i]) begin
            if (exp_req_q[i].size() == 0) begin
              vectors++; miscompares++;
              $display("[TB] FAIL unexpected_req_lane%0d: got %h expected no request", i, memreq_msg[i*RQ +: RQ]);
            end else begin
              checkOutput($sformatf("req_lane%0d", i), 128'(memreq_msg[i*RQ +: RQ]), 128'(exp_req_q[i][0]));
              if (memreq_rdy[i]) void'(exp_req_q[i].pop_front());
            end
          end
        end
      end
    end
  end

  // Response monitor: resp_data must match the head of the response queue
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && resp_val) begin
        checkOutput("cmd_rdy_while_done", 128'(cmd_rdy), 128'(0));
        if (exp_resp_q.size() == 0) begin
          vectors++; miscompares++;
          $display("[TB] FAIL unexpected_resp: got %h expected no response", resp_data);
        end else begin
          checkOutput("resp_data", 128'(resp_data), 128'(exp_resp_q[0]));
          if (resp_rdy) void'(exp_resp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc;
    int acc2;
    cmd_val = 0; cmd_rw = 0; cmd_len = 0; cmd_base = 0; cmd_stride = 0;
    cmd_mask = 0; cmd_wdata = 0; resp_rdy = 1; memreq_rdy = '1;
    man_val = '0; man_msg = '0; auto_mem = 1'b1;

    // Reset state
    repeat (2) nextCycle();
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_cmd_rdy", 128'(cmd_rdy), 128'(1));
    checkOutput("reset_resp_val", 128'(resp_val), 128'(0));
    checkOutput("reset_memreq_val", 128'(memreq_val), 128'(0));
    checkOutput("reset_resp_data", 128'(resp_data), 128'(0));
    nextCycle();

    // Unit-stride word load
    $display("[TB] unit-stride load");
    expectReq(0, 0, 32'h1000, 2'd0, 0); expectReq(1, 0, 32'h1004, 2'd0, 0);
    expectReq(2, 0, 32'h1008, 2'd0, 0); expectReq(3, 0, 32'h100C, 2'd0, 0);
    exp_resp_q.push_back({32'h5A5A100C, 32'h5A5A1008, 32'h5A5A1004, 32'h5A5A1000});
    applyStimulus(0, 2'd0, 32'h1000, 32'd4, 4'b1111, '0, acc);
    @(negedge clk);
    checkOutput("load_req_cycle1", 128'(memreq_val), 128'(4'b1111));
    waitResp("load_latency", acc, 3);

    // Negative-stride store
    $display("[TB] negative-stride store");
    expectReq(0, 1, 32'h2000, 2'd0, 32'hA); expectReq(1, 1, 32'h1FF8, 2'd0, 32'hB);
    expectReq(2, 1, 32'h1FF0, 2'd0, 32'hC); expectReq(3, 1, 32'h1FE8, 2'd0, 32'hD);
    exp_resp_q.push_back('0);
    applyStimulus(1, 2'd0, 32'h2000, 32'hFFFFFFF8, 4'b1111,
                  {32'hD, 32'hC, 32'hB, 32'hA}, acc);
    waitResp("store_latency", acc, 3);

    // Partial mask byte load
    $display("[TB] partial mask load");
    expectReq(0, 0, 32'h1000, 2'd1, 0); expectReq(2, 0, 32'h1008, 2'd1, 0);
    exp_resp_q.push_back({32'h0, 32'h5A5A1008, 32'h0, 32'h5A5A1000});
    applyStimulus(0, 2'd1, 32'h1000, 32'd4, 4'b0101, '0, acc);
    @(negedge clk);
    checkOutput("partial_req_cycle1", 128'(memreq_val), 128'(4'b0101));
    waitResp("partial_latency", acc, 3);

    // Empty mask
    $display("[TB] empty mask");
    exp_resp_q.push_back('0);
    applyStimulus(0, 2'd0, 32'h5000, 32'd4, 4'b0000, {4{32'hFFFF_FFFF}}, acc);
    waitResp("mask0_latency", acc, 1);

    // Lane 2 backpressured for five cycles
    $display("[TB] backpressure on lane 2");
    memreq_rdy = 4'b1011;
    expectReq(0, 0, 32'h6000, 2'd0, 0); expectReq(1, 0, 32'h6100, 2'd0, 0);
    expectReq(2, 0, 32'h6200, 2'd0, 0); expectReq(3, 0, 32'h6300, 2'd0, 0);
    exp_resp_q.push_back({32'h5A5A6300, 32'h5A5A6200, 32'h5A5A6100, 32'h5A5A6000});
    applyStimulus(0, 2'd0, 32'h6000, 32'h100, 4'b1111, '0, acc);
    repeat (4) nextCycle();
    @(negedge clk);
    checkOutput("bp_only_lane2_pending", 128'(memreq_val), 128'(4'b0100));
    checkOutput("bp_no_resp_yet", 128'(resp_val), 128'(0));
    nextCycle();
    memreq_rdy = 4'b1111;
    waitResp("bp_latency", acc, 8);

    // Out-of-order, duplicate and spurious responses with held result
    $display("[TB] out-of-order responses");
    auto_mem = 1'b0;
    resp_rdy = 1'b0;
    expectReq(0, 0, 32'h4000, 2'd0, 0); expectReq(1, 0, 32'h4010, 2'd0, 0);
    expectReq(2, 0, 32'h4020, 2'd0, 0); expectReq(3, 0, 32'h4030, 2'd0, 0);
    exp_resp_q.push_back({32'h5A5A4030, 32'h5A5A4020, 32'h5A5A4010, 32'h5A5A4000});
    applyStimulus(0, 2'd0, 32'h4000, 32'h10, 4'b1111, '0, acc);
    nextCycle();
    manDrive(4'b1000, {32'h5A5A4030, 96'h0});
    nextCycle();
    manDrive(4'b0001, {96'h0, 32'h5A5A4000});
    nextCycle();
    manDrive(4'b0101, {32'h0, 32'h5A5A4020, 32'h0, 32'hBAD0BAD0});
    nextCycle();
    manDrive(4'b0010, {64'h0, 32'h5A5A4010, 32'h0});
    nextCycle();
    manDrive(4'b0010, {64'h0, 32'hBAD1BAD1, 32'h0});
    @(negedge clk);
    checkOutput("ooo_resp_val_cycle6", 128'(resp_val), 128'(1));
    nextCycle();
    manDrive('0, '0);
    repeat (2) nextCycle();
    resp_rdy = 1'b1;
    nextCycle();
    @(negedge clk);
    checkOutput("ooo_retired_resp_val", 128'(resp_val), 128'(0));
    checkOutput("ooo_retired_cmd_rdy", 128'(cmd_rdy), 128'(1));
    nextCycle();

    // Reset while lanes 2 and 3 are outstanding
    $display("[TB] reset mid-operation");
    expectReq(0, 0, 32'h3000, 2'd0, 0); expectReq(1, 0, 32'h3004, 2'd0, 0);
    expectReq(2, 0, 32'h3008, 2'd0, 0); expectReq(3, 0, 32'h300C, 2'd0, 0);
    applyStimulus(0, 2'd0, 32'h3000, 32'd4, 4'b1111, '0, acc);
    nextCycle();
    manDrive(4'b0011, {64'h0, 32'h5A5A3004, 32'h5A5A3000});
    nextCycle();
    manDrive('0, '0);
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    manDrive(4'b1100, {32'hDEAD0003, 32'hDEAD0002, 64'h0});
    @(negedge clk);
    checkOutput("midrst_cmd_rdy", 128'(cmd_rdy), 128'(1));
    checkOutput("midrst_resp_val", 128'(resp_val), 128'(0));
    checkOutput("midrst_resp_data", 128'(resp_data), 128'(0));
    checkOutput("midrst_memreq_val", 128'(memreq_val), 128'(0));
    nextCycle();
    manDrive('0, '0);
    @(negedge clk);
    checkOutput("late_resp_ignored_cmd_rdy", 128'(cmd_rdy), 128'(1));
    checkOutput("late_resp_ignored_resp_val", 128'(resp_val), 128'(0));
    nextCycle();
    auto_mem = 1'b1;
    expectReq(0, 0, 32'h3000, 2'd0, 0); expectReq(1, 0, 32'h3004, 2'd0, 0);
    expectReq(2, 0, 32'h3008, 2'd0, 0); expectReq(3, 0, 32'h300C, 2'd0, 0);
    exp_resp_q.push_back({32'h5A5A300C, 32'h5A5A3008, 32'h5A5A3004, 32'h5A5A3000});
    applyStimulus(0, 2'd0, 32'h3000, 32'd4, 4'b1111, '0, acc);
    waitResp("post_reset_latency", acc, 3);

    // Back-to-back commands
    $display("[TB] back-to-back commands");
    expectReq(0, 0, 32'h7000, 2'd0, 0); expectReq(1, 0, 32'h7004, 2'd0, 0);
    exp_resp_q.push_back({64'h0, 32'h5A5A7004, 32'h5A5A7000});
    expectReq(2, 0, 32'h8010, 2'd0, 0); expectReq(3, 0, 32'h8018, 2'd0, 0);
    exp_resp_q.push_back({32'h5A5A8018, 32'h5A5A8010, 64'h0});
    applyStimulus(0, 2'd0, 32'h7000, 32'd4, 4'b0011, '0, acc);
    applyStimulus(0, 2'd0, 32'h8000, 32'd8, 4'b1100, '0, acc2);
    checkOutput("b2b_spacing", 128'(acc2 - acc), 128'(4));
    waitResp("b2b_latency", acc2, 3);

    repeat (3) nextCycle();
    checkOutput("req_queue_drained", 128'(exp_req_q[0].size() + exp_req_q[1].size() +
                exp_req_q[2].size() + exp_req_q[3].size()), 128'(0));
    checkOutput("resp_queue_drained", 128'(exp_resp_q.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
